// File: rtl/disp_arb.sv
// Arbitrates the 4-digit seven-segment display between requesters A and B:
// minimum hold per owner, round-robin on contention, one blank gap cycle, optional blink.
module disp_arb #(
  parameter int HOLD_CYC = 1000000,
  parameter int HOLD_W   = 20,
  parameter int BLINK_W  = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_a,
  input  logic [31:0] data_a,
  output logic        gnt_a,
  input  logic        req_b,
  input  logic [31:0] data_b,
  output logic        gnt_b,
  input  logic        blink_en,
  output logic [1:0]  owner,
  output logic [7:0]  in3,
  output logic [7:0]  in2,
  output logic [7:0]  in1,
  output logic [7:0]  in0
);
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, GAP} state_t;
  localparam logic [31:0] BLANK = 32'hFFFF_FFFF;

  state_t             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [BLINK_W-1:0] blink_q;
  logic               last_b_q, last_b_d;
  logic [31:0]        lat_q, lat_d, disp_q, disp_d;
  logic               gnt_a_q, gnt_b_q;
  logic [1:0]         owner_q;
  logic               own_q, own_d;

  assign own_q = (state_q == OWN_A) || (state_q == OWN_B);
  assign own_d = (state_d == OWN_A) || (state_d == OWN_B);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, GAP: begin
        if (req_a && req_b) state_d = last_b_q ? OWN_A : OWN_B;
        else if (req_a)     state_d = OWN_A;
        else if (req_b)     state_d = OWN_B;
        else                state_d = IDLE;
      end
      // Once the hold expires, a waiting rival preempts even a still-requesting owner.
      OWN_A: if (hold_q == '0 && (req_b || !req_a)) state_d = GAP;
      OWN_B: if (hold_q == '0 && (req_a || !req_b)) state_d = GAP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hold_d   = hold_q;
    last_b_d = last_b_q;
    lat_d    = lat_q;
    if (own_d && !own_q) begin
      hold_d   = HOLD_W'(HOLD_CYC - 1);
      last_b_d = (state_d == OWN_B);
    end else if (own_q && hold_q != '0) begin
      hold_d = hold_q - HOLD_W'(1);
    end
    if (state_d == OWN_A && req_a)      lat_d = data_a;
    else if (state_d == OWN_B && req_b) lat_d = data_b;
    // Show the latch only while ownership continues; entry and exit cycles stay blank.
    disp_d = (own_q && state_d == state_q) ? lat_q : BLANK;
    if (blink_en && blink_q[BLINK_W-1]) disp_d = BLANK;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      blink_q  <= '0;
      last_b_q <= 1'b1;
      lat_q    <= '0;
      disp_q   <= BLANK;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      owner_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      blink_q  <= blink_q + BLINK_W'(1);
      last_b_q <= last_b_d;
      lat_q    <= lat_d;
      disp_q   <= disp_d;
      gnt_a_q  <= (state_d == OWN_A);
      gnt_b_q  <= (state_d == OWN_B);
      owner_q  <= {state_d == OWN_B, state_d == OWN_A};
    end
  end

  assign gnt_a = gnt_a_q;
  assign gnt_b = gnt_b_q;
  assign owner = owner_q;
  assign in3   = disp_q[31:24];
  assign in2   = disp_q[23:16];
  assign in1   = disp_q[15:8];
  assign in0   = disp_q[7:0];
endmodule

// File: doc/disp_arb.md
Name: disp_arb

Overview:
- Arbitrates ownership of the 4-digit seven-segment display between two requesters, A and B.
- Each requester presents four 8-bit segment patterns, one per digit. The winner's patterns drive the in3..in0 inputs of the downstream 4-digit display multiplexer.
- Enforces a minimum hold time per owner, round-robin fairness under contention, a one-cycle blank gap between owners, and optional blinking.

Parameters:
- HOLD_CYC, 1000000, minimum cycles an owner keeps the display once granted (>= 2)
- HOLD_W, 20, width of hold counter (2^HOLD_W > HOLD_CYC)
- BLINK_W, 24, width of free-running blink counter; its MSB is the blink phase

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_a  in  1  requester A wants the display
- data_a  in  32  A patterns: [31:24]=digit3 … [7:0]=digit0; segments active-low
- gnt_a  out  1  A currently owns the display
- req_b  in  1  requester B wants the display
- data_b  in  32  B patterns, same layout as data_a
- gnt_b  out  1  B currently owns the display
- blink_en  in  1  blank the outputs during the blink-off phase
- owner  out  2  00 none, 01 A, 10 B
- in3, in2, in1, in0  out  8 each  segment patterns to the display mux

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
  - State = IDLE; hold counter = 0; blink counter = 0; last_owner = B, so A wins the first tie.
  - gnt_a = gnt_b = 0; owner = 00; in3..in0 = 8'hFF (all segments off).
- All outputs are registered.
- States: IDLE, OWN_A, OWN_B, GAP.
- IDLE
  - Outputs blank.
  - Exactly one req high → go to that requester's OWN state next cycle.
  - Both req high → grant the requester that is not last_owner.
- OWN_x, on entry:
  - gnt_x = 1 and owner updated in the same cycle the state is entered.
  - Hold counter loaded with HOLD_CYC-1.
  - last_owner = x.
- OWN_x, each cycle:
  - Hold counter decrements, saturating at 0.
  - While req_x = 1, the displayed latch captures data_x. data_x sampled at edge t appears on in3..in0 after edge t+1 (1-cycle latency).
  - When req_x = 0, the latch freezes at the last pattern captured while req_x was high.
- OWN_x exit, evaluated when hold counter = 0:
  - Other requester high → GAP. This is time-slice preemption and applies even if req_x is still high.
  - Else req_x = 0 → GAP.
  - Else (req_x high, other low) → stay; the counter remains 0 and is re-evaluated every cycle.
- A req_x drop before the hold expires does not end ownership. The frozen data stays displayed until expiry.
- GAP
  - Exactly one cycle; gnt_a = gnt_b = 0; owner = 00; outputs blank.
  - Next state:
    - Both req high → OWN of the requester that is not last_owner.
    - One req high → that requester's OWN state, even if it was last_owner.
    - No req → IDLE.
- Mutual exclusion: gnt_a and gnt_b are never both 1. A grant is never asserted in IDLE or GAP.
- Blink:
  - The blink counter free-runs, increments every cycle and wraps modulo 2^BLINK_W.
  - If blink_en = 1 and the counter MSB = 1, in3..in0 = 8'hFF regardless of state.
  - Blinking does not affect gnt, owner, hold or the latched data.
  - blink_en takes effect with 1-cycle latency.
- Requesters must hold data stable only while they are sampled. No ready/valid beyond req/gnt.
- Reset mid-ownership: immediate return to reset values. The pre-reset owner does not count as last_owner.

Test Plan:
- Bench parameters: HOLD_CYC=4, BLINK_W=3.
- Reset with req_a=1, data_a=32'h11223344:
  - All outputs blank/0 during reset.
  - 1 cycle after release: gnt_a=1, owner=01.
  - Next cycle: in3=8'h11, in0=8'h44.
- Both requesting forever:
  - Grants alternate A(4 cycles), GAP(1), B(4), GAP(1), A…
  - gnt_a and gnt_b never both high; outputs 8'hFF in every GAP cycle.
- A granted, req_a dropped after 1 cycle while data_a changes to 32'hFFFF0000:
  - Display holds the earlier value until hold expiry.
  - Then GAP, then IDLE, with in* = 8'hFF.
- A alone, requesting continuously for 20 cycles:
  - gnt_a stays 1 throughout with no GAP.
  - req_b raised at cycle 10 → GAP within 1 cycle, then gnt_b.
- blink_en=1 during OWN_A:
  - in* toggles between data_a patterns and 8'hFF every 4 cycles.
  - gnt_a and owner are unchanged.
- Async reset asserted mid-OWN_B, with both req held high:
  - Outputs clear immediately, without waiting for a clock edge.
  - After release, A is granted first.
